// File: rtl/fetch_ctrl_pkg.sv
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared constants and types for the instruction fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_ctrl_pkg;

    localparam logic [31:0] C_RESET_PC  = 32'h0000_0000;
    localparam int          C_BUF_DEPTH = 2;
    localparam logic [31:0] C_WORD_INC  = 32'd4;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } buf_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_buf.sv
// ============================================================================
// Module      : fetch_buf
// Description : Two-entry FIFO of fetched {pc, instr} pairs with flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buf
    import fetch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_flush,
    input  buf_entry_t i_push_data,
    output logic [1:0] o_count,
    output buf_entry_t o_head
);

    buf_entry_t r_entry0;
    buf_entry_t r_entry1;
    logic [1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry0 <= '0;
            r_entry1 <= '0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_entry0 <= i_push_data;
                        r_count  <= 2'd1;
                    end else if (r_count == 2'd1) begin
                        r_entry1 <= i_push_data;
                        r_count  <= 2'd2;
                    end
                end
                2'b01: begin
                    if (r_count != 2'd0) begin
                        r_entry0 <= r_entry1;
                        r_count  <= r_count - 2'd1;
                    end
                end
                2'b11: begin
                    // Pop of an empty buffer degenerates to a plain push.
                    if (r_count == 2'd2) begin
                        r_entry0 <= r_entry1;
                        r_entry1 <= i_push_data;
                    end else begin
                        r_entry0 <= i_push_data;
                        r_count  <= 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_entry0;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction fetch controller: ROM sequencing, redirects,
//               misaligned-redirect fault and a 2-entry output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = C_RESET_PC,
    parameter int          BUF_DEPTH = C_BUF_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_fault
);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_fetch_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;

    logic        w_run;
    logic        w_redir;
    logic        w_redir_ok;
    logic        w_pop;
    logic        w_push;
    logic        w_flush;
    logic        w_issue;
    logic [1:0]  w_count;
    logic [1:0]  w_occ_next;
    buf_entry_t  w_push_data;
    buf_entry_t  w_head;

    assign w_run      = (r_state == ST_RUN);
    assign w_redir    = w_run && redirect_valid;
    assign w_redir_ok = w_redir && (redirect_pc[1:0] == 2'b00);

    assign out_valid  = w_run && (w_count != 2'd0);
    assign w_pop      = out_valid && out_ready;

    // Occupancy the buffer would reach after this cycle's pop and pending push.
    assign w_occ_next = (w_count - {1'b0, w_pop}) + {1'b0, r_inflight};
    assign w_issue    = w_run && !redirect_valid
                        && ({30'd0, w_occ_next} < 32'(BUF_DEPTH));

    assign w_push      = w_run && !redirect_valid && r_inflight;
    assign w_flush     = w_redir || !w_run;
    assign w_push_data = '{pc: r_inflight_pc, instr: imem_rdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                    w_state_next = ST_FAULT;
                end
            end
            ST_FAULT: begin
                w_state_next = ST_FAULT;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            // A response is either pushed or dropped the cycle after issue.
            r_inflight <= w_issue;
            if (w_redir_ok) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + C_WORD_INC;
            end
        end
    end

    fetch_buf u_fetch_buf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .i_push_data (w_push_data),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign imem_addr   = r_fetch_pc;
    assign out_pc      = w_head.pc;
    assign out_instr   = w_head.instr;
    assign fetch_fault = (r_state == ST_FAULT);

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

    typedef logic [31:0] u32_t;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;

    int total;
    int bad;

    // Expected fetch-side state: PCs waiting in the buffer, the request in
    // flight, the next fetch address and the sticky fault.
    u32_t m_q[$];
    bit   m_infl;
    u32_t m_ipc;
    u32_t m_fpc;
    bit   m_fault;

    fetch_ctrl u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic u32_t rom(input u32_t a);
        return {2'b00, a[31:2]};
    endfunction

    always @(posedge clk) imem_rdata <= rom(imem_addr);

    task automatic chk(input string tag, input u32_t obs, input u32_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit exp_valid;
        exp_valid = !m_fault && (m_q.size() > 0);
        chk("imem_addr", imem_addr, m_fpc);
        chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("out_pc", out_pc, m_q[0]);
            chk("out_instr", out_instr, rom(m_q[0]));
        end
    endtask

    // One clock cycle: check, drive, advance model, cross the edge.
    task automatic step(input bit rv, input u32_t rpc, input bit rdy);
        int occ;
        bit iss;
        check_outputs();
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        if (!m_fault) begin
            if (rv) begin
                m_q.delete();
                m_infl = 1'b0;
                if (rpc[1:0] != 2'b00) m_fault = 1'b1;
                else                   m_fpc   = rpc;
            end else begin
                if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
                occ = m_q.size() + int'(m_infl);
                iss = (occ < 2);
                if (m_infl) m_q.push_back(m_ipc);
                m_infl = iss;
                if (iss) begin
                    m_ipc = m_fpc;
                    m_fpc = m_fpc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse issued between edges.
    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        m_q.delete();
        m_infl  = 1'b0;
        m_ipc   = '0;
        m_fpc   = 32'h0;
        m_fault = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        u32_t tgt;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        #2;
        do_reset();

        // Streaming with consumer always ready.
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

        // Back-pressure fills the buffer, fetch address parks at 8.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0);
        chk("hold_addr", imem_addr, 32'h8);
        chk("hold_pc", out_pc, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

        // Aligned redirect at cycle 10.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

        // Redirect at the top of the address space wraps.
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

        // Misaligned redirect faults; aligned redirect afterwards is ignored.
        step(1'b1, 32'h102, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b1, 32'h200, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

        // Reset with a full buffer.
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ((m_fault && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 99) < 6) begin
                case ($urandom_range(0, 9))
                    0:       tgt = $urandom() | 32'h1;
                    1:       tgt = 32'hFFFF_FFF8;
                    default: tgt = $urandom() & 32'hFFFF_FFFC;
                endcase
                step(1'b1, tgt, 1'($urandom_range(0, 3) != 0));
            end else begin
                step(1'b0, 32'($urandom()), 1'($urandom_range(0, 3) != 0));
            end
        end
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset; SHALL be word-aligned.
REQ-002 Parameter BUF_DEPTH, default 2, output-buffer entries; only the value 2 SHALL be supported.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 imem_addr  out  32  byte address to instruction ROM; ROM returns word one cycle later.
REQ-006 imem_rdata  in  32  ROM data for the address presented in the previous cycle.
REQ-007 redirect_valid  in  1  branch/jump redirect request.
REQ-008 redirect_pc  in  32  redirect target byte address.
REQ-009 out_valid  out  1  out_instr/out_pc hold a valid fetched instruction.
REQ-010 out_ready  in  1  consumer accepts; transfer when out_valid & out_ready.
REQ-011 out_instr  out  32  fetched instruction word.
REQ-012 out_pc  out  32  byte address of out_instr.
REQ-013 fetch_fault  out  1  sticky misaligned-redirect fault.

Function
REQ-014 imem_addr SHALL equal the registered fetch_pc (no combinational path from any input).
REQ-015 A fetch is issued in a cycle iff state=RUN, no redirect, and (buffer occupancy + in-flight) < 2 after this cycle's pop; issue sets in-flight flag and in-flight PC = fetch_pc, fetch_pc <= fetch_pc + 4.
REQ-016 fetch_pc increment SHALL be modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-017 A non-issuing cycle SHALL hold fetch_pc; the ROM response that cycle SHALL be ignored.
REQ-018 In-flight response SHALL be written to the buffer with its PC at the edge ending the cycle after issue; out_valid rises the following cycle (issue at N -> out_valid at N+2).
REQ-019 Buffer SHALL be FIFO-ordered; a pop and push in the same cycle at occupancy 2 is not possible by REQ-015; push and pop together at occupancy 1 SHALL keep occupancy 1.
REQ-020 out_valid = buffer non-empty; out_instr/out_pc SHALL be the head entry and stable while out_valid & !out_ready.
REQ-021 States: RUN, FAULT. RUN->FAULT on redirect_valid with redirect_pc[1:0] != 0; FAULT exits only via rst.
REQ-022 Aligned redirect in RUN SHALL have priority over issue/push: flush buffer, drop in-flight response, fetch_pc <= redirect_pc, no issue that cycle; redirect at R -> imem_addr=target at R+1 -> out_valid at R+3 with out_pc=target.
REQ-023 A handshake coinciding with a redirect SHALL count as a completed transfer; the entry is then discarded with the flush.
REQ-024 In FAULT: fetch_fault=1, no issue, buffer flushed, out_valid=0, imem_addr holds last value.
REQ-025 redirect_valid in FAULT SHALL be ignored.

Reset
REQ-026 rst asserted SHALL immediately force: state=RUN, fetch_pc=RESET_PC, in-flight=0, buffer empty, out_valid=0, fetch_fault=0, out_instr=0, out_pc=0.
REQ-027 Reset mid-operation SHALL discard all buffered and in-flight data; first issue at RESET_PC in the first cycle after rst deasserts.

Structure
REQ-028 Shared package SHALL hold RESET_PC default, the state encoding (RUN, FAULT), BUF_DEPTH, and the word-increment constant 4.
REQ-029 The 2-entry {pc, instr} buffer SHALL be a sub-module fetch_buf with push, pop, flush, count, head outputs.

Verification
REQ-030 Reset, out_ready=1, ROM[i]=i -> out_valid at cycle 2; out_pc 0,4,8,... one per cycle, out_instr 0,1,2,...
REQ-031 out_ready=0 from cycle 0 -> occupancy reaches 2, imem_addr holds 32'h8, out_pc stays 0; release ready -> pc 0,4,8 in order, no loss/duplication.
REQ-032 Redirect to 32'h100 at cycle 10 with ready=1 -> no out_pc from the old stream after cycle 10; out_valid with out_pc 32'h100 at cycle 13.
REQ-033 Redirect to 32'hFFFF_FFFC -> out_pc sequence FFFF_FFFC, 0000_0000, 0000_0004.
REQ-034 Redirect to 32'h102 -> fetch_fault=1 next cycle, out_valid=0 thereafter, later aligned redirect ignored; rst clears fault, fetch restarts at RESET_PC.
REQ-035 rst pulse mid-stream with occupancy 2 -> out_valid=0 asynchronously, restart at RESET_PC with no stale entries.
